pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Consumer end of the branch controller's jmp_addr/jmp_enable interface: owns the word-addressed PC.
//   Fetches one instruction at a time from instruction memory over a req/rvalid handshake.
//   Presents the fetched word to the core with a valid/ready handshake.
//   On retire, loads PC with jmp_addr when jmp_enable is set, else PC+1.
// PARAMETERS
//   RESET_VEC    30'h0000_0000  word address of first fetch after reset
//   TIMEOUT      16             max cycles in WAIT before fetch_fault; 1..65535
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous reset, active-high
//   imem_req     out  1   one-cycle fetch request pulse
//   imem_addr    out  30  word address of request; equals pc
//   imem_rvalid  in   1   response valid; exactly one per req
//   imem_rdata   in   32  instruction word, valid with imem_rvalid
//   instr        out  32  held instruction word
//   instr_pc     out  30  word address of instr
//   instr_valid  out  1   instr/instr_pc valid
//   instr_ready  in   1   core retires instr this cycle
//   jmp_enable   in   1   take jmp_addr as next PC; sampled only on retire
//   jmp_addr     in   30  branch/jump target, word address
//   fetch_fault  out  1   sticky: memory did not answer within TIMEOUT
//   instret      out  32  count of retired instructions
// BEHAVIOUR
//   Reset (async, immediate): state=ISSUE, pc=RESET_VEC, instr=0, instr_pc=0, instr_valid=0,
//     fetch_fault=0, instret=0, timeout counter=0; imem_req=0 while rst high.
//   Any in-flight fetch is abandoned on reset. Memory shares rst and drops stale responses.
//   States:
//     ISSUE: imem_req=1, imem_addr=pc for this one cycle -> WAIT. imem_rvalid here is ignored.
//     WAIT:  imem_req=0, counter increments each cycle.
//       imem_rvalid=1 -> instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, counter<=0 -> HOLD.
//       counter reaches TIMEOUT with no rvalid -> fetch_fault<=1 -> FAULT.
//     HOLD:  instr_valid=1; instr and instr_pc stable until retire.
//       instr_ready=1 is a retire: instr_valid<=0, instret<=instret+1, -> ISSUE.
//         pc <= jmp_enable ? jmp_addr : pc+1.
//     FAULT: terminal until reset; imem_req=0, instr_valid=0, fetch_fault=1.
//   jmp_enable/jmp_addr are ignored in every cycle that is not a retire.
//   pc+1 and instret wrap modulo 2^30 and 2^32; no flag is raised on wrap.
//   Jump to the current pc (self-loop) is legal; the same address is refetched.
//   Latency: ISSUE->rvalid is N>=1 cycles; instr_valid rises the cycle after rvalid.
//   Throughput: best case one instruction per 3 cycles (ISSUE, WAIT with rvalid, HOLD with ready).
//   imem_addr equals pc in all states; it is meaningful only while imem_req=1.
//   instr_ready while instr_valid=0 has no effect.
// TESTING
//   1 Reset release, RESET_VEC=0x100, rvalid 1 cycle after req, ready held 1 ->
//     imem_addr sequence 0x100,0x101,0x102; instret=3 after 3 retires.
//   2 Retire at instr_pc=0x104 with jmp_enable=1, jmp_addr=0x040 -> next imem_addr=0x040.
//     instr_pc=0x040 on the following instruction.
//   3 jmp_enable=1, jmp_addr=0x200 pulsed in WAIT and in HOLD with ready=0, then retire with jmp_enable=0
//     -> next fetch at instr_pc+1; 0x200 is never requested.
//   4 Hold instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, no imem_req.
//     Then ready=1 -> single retire and instret+1.
//   5 TIMEOUT=4, withhold rvalid -> fetch_fault=1 after 4 WAIT cycles.
//     A later rvalid is ignored; only rst clears the fault, and the next fetch is at RESET_VEC.
//   6 pc=0x3FFF_FFFF, retire with jmp_enable=0 -> next imem_addr=0x0000_0000.
//     Separately, assert rst mid-WAIT -> outputs reset the same cycle; fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-unit bus bundle (imem req/rvalid, instr valid/ready, jump target, status)
//   master: the fetch unit; slave: memory/core/branch side
interface pc_fetch_if;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [29:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jmp_enable;
  logic [29:0] jmp_addr;
  logic        fetch_fault;
  logic [31:0] instret;
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_fault, instret,
    input  imem_rvalid, imem_rdata, instr_ready, jmp_enable, jmp_addr
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_fault, instret,
    output imem_rvalid, imem_rdata, instr_ready, jmp_enable, jmp_addr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the word PC, fetches one instruction at a time, holds it until the core retires it
//   clk, rst (async, active-high); bus: pc_fetch_if.master carrying
//   imem_req/imem_addr/imem_rvalid/imem_rdata, instr/instr_pc/instr_valid/instr_ready,
//   jmp_enable/jmp_addr (used only on retire), fetch_fault (sticky), instret
module pc_fetch_unit #(
  parameter logic [29:0] RESET_VEC = 30'h0,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic         clk,
  input logic         rst,
  pc_fetch_if.master  bus
);
  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, FAULT} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  state_t      state, state_n;
  logic [29:0] pc;
  logic [15:0] cnt;
  logic        retire;
  logic        got;
  always_comb begin
    retire  = state == HOLD && bus.instr_ready;
    got     = state == WAIT && bus.imem_rvalid;
    state_n = state;
    case (state)
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = bus.imem_rvalid ? HOLD : (cnt == LAST ? FAULT : WAIT);
      HOLD:    state_n = retire ? ISSUE : HOLD;
      default: state_n = FAULT;
    endcase
  end
  // req is gated by rst so nothing is requested while reset is held
  assign bus.imem_req    = state == ISSUE && !rst;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = state == HOLD;
  assign bus.fetch_fault = state == FAULT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ISSUE;
    else     state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_VEC;
      cnt          <= '0;
      bus.instr    <= '0;
      bus.instr_pc <= '0;
      bus.instret  <= '0;
    end else begin
      cnt <= (state == WAIT && !bus.imem_rvalid) ? cnt + 16'd1 : '0;
      if (got) begin
        bus.instr    <= bus.imem_rdata;
        bus.instr_pc <= pc;
      end
      if (retire) begin
        pc          <= bus.jmp_enable ? bus.jmp_addr : pc + 30'd1;
        bus.instret <= bus.instret + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit with a behavioural instruction memory
module tb_pc_fetch_unit;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  pc_fetch_if bus ();
  pc_fetch_unit #(.RESET_VEC(30'h100), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  int retired = 0;
  logic [29:0] exp_addr[$];
  logic [29:0] exp_pc[$];
  bit          mem_on = 1;
  int          mem_delay = 0;
  bit          inject = 0;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [29:0] pend_addr = '0;
  logic [29:0] e;
  function automatic logic [31:0] word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hA5A5_0000;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_retired(input int n);
    int k = 0;
    while (retired != n && k < 200) begin
      step();
      k++;
    end
    total++;
    if (retired != n) begin
      bad++;
      $display("FAIL wait_retired: got %0d retires, expected %0d", retired, n);
    end
  endtask
  task automatic wait_valid();
    int k = 0;
    while (bus.instr_valid !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    total++;
    if (bus.instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL wait_valid: instr_valid=%b, expected 1", bus.instr_valid);
    end
  endtask
  task automatic test_reset();
    step();
    total++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: req=%b valid=%b fault=%b, expected 0 0 0", bus.imem_req, bus.instr_valid, bus.fetch_fault);
    end
    total++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 30'h0 || bus.instret !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: instr=%h instr_pc=%h instret=%0d, expected 0 0 0", bus.instr, bus.instr_pc, bus.instret);
    end
  endtask
  task automatic test_sequential();
    exp_addr.push_back(30'h100); exp_addr.push_back(30'h101);
    exp_addr.push_back(30'h102); exp_addr.push_back(30'h103);
    exp_pc.push_back(30'h100); exp_pc.push_back(30'h101); exp_pc.push_back(30'h102);
    bus.instr_ready = 1;
    rst = 0;
    wait_retired(3);
    bus.instr_ready = 0;
    total++;
    if (bus.instret !== 32'd3) begin
      bad++;
      $display("FAIL seq_instret: instret=%0d, expected 3", bus.instret);
    end
  endtask
  task automatic test_jump();
    exp_pc.push_back(30'h103); exp_pc.push_back(30'h104);
    exp_addr.push_back(30'h104); exp_addr.push_back(30'h040);
    bus.instr_ready = 1;
    wait_retired(4);
    bus.jmp_enable = 1;
    bus.jmp_addr = 30'h040;
    wait_retired(5);
    bus.jmp_enable = 0;
    bus.instr_ready = 0;
    wait_valid();
    total++;
    if (bus.instr_pc !== 30'h040 || bus.instr !== word(30'h040)) begin
      bad++;
      $display("FAIL jump_target: instr_pc=%h instr=%h, expected 040 %h", bus.instr_pc, bus.instr, word(30'h040));
    end
  endtask
  task automatic test_jmp_ignored();
    exp_pc.push_back(30'h040); exp_pc.push_back(30'h041);
    exp_addr.push_back(30'h041); exp_addr.push_back(30'h042);
    bus.jmp_enable = 1;
    bus.jmp_addr = 30'h200;
    step();
    bus.jmp_enable = 0;
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 30'h040) begin
      bad++;
      $display("FAIL jmp_hold_noretire: valid=%b instr_pc=%h, expected 1 040", bus.instr_valid, bus.instr_pc);
    end
    bus.instr_ready = 1;
    wait_retired(6);
    bus.instr_ready = 0;
    step();
    bus.jmp_enable = 1;
    step();
    bus.jmp_enable = 0;
    bus.instr_ready = 1;
    wait_retired(7);
    bus.instr_ready = 0;
  endtask
  task automatic test_hold_stable();
    wait_valid();
    exp_pc.push_back(30'h042);
    exp_addr.push_back(30'h043);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.instr_pc !== 30'h042 || bus.instr !== word(30'h042) || bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable[%0d]: pc=%h instr=%h valid=%b req=%b, expected 042 %h 1 0", i, bus.instr_pc, bus.instr, bus.instr_valid, bus.imem_req, word(30'h042));
      end
      step();
    end
    bus.instr_ready = 1;
    step();
    bus.instr_ready = 0;
    repeat (3) step();
    total++;
    if (bus.instret !== 32'd8 || retired != 8) begin
      bad++;
      $display("FAIL hold_single_retire: instret=%0d retired=%0d, expected 8", bus.instret, retired);
    end
  endtask
  task automatic test_wrap();
    wait_valid();
    exp_pc.push_back(30'h043); exp_pc.push_back(30'h3FFF_FFFF);
    exp_addr.push_back(30'h3FFF_FFFF); exp_addr.push_back(30'h0);
    bus.jmp_enable = 1;
    bus.jmp_addr = 30'h3FFF_FFFF;
    bus.instr_ready = 1;
    wait_retired(9);
    bus.jmp_enable = 0;
    wait_retired(10);
    bus.instr_ready = 0;
    wait_valid();
    total++;
    if (bus.instr_pc !== 30'h0 || bus.instret !== 32'd10) begin
      bad++;
      $display("FAIL wrap: instr_pc=%h instret=%0d, expected 0 10", bus.instr_pc, bus.instret);
    end
  endtask
  task automatic test_reset_midwait();
    mem_delay = 3;
    exp_pc.push_back(30'h0);
    exp_addr.push_back(30'h1);
    bus.instr_ready = 1;
    wait_retired(11);
    bus.instr_ready = 0;
    step();
    step();
    rst = 1;
    #1;
    total++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fetch_fault !== 1'b0 || bus.instret !== 32'h0 || bus.instr !== 32'h0) begin
      bad++;
      $display("FAIL midwait_reset: req=%b valid=%b fault=%b instret=%0d instr=%h, expected all 0", bus.imem_req, bus.instr_valid, bus.fetch_fault, bus.instret, bus.instr);
    end
    step();
    mem_delay = 0;
    total++;
    if (exp_addr.size() != 0) begin
      bad++;
      $display("FAIL midwait_pending: %0d addresses outstanding, expected 0", exp_addr.size());
    end
    exp_addr.push_back(30'h100); exp_addr.push_back(30'h101);
    exp_pc.push_back(30'h100);
    bus.instr_ready = 1;
    rst = 0;
    wait_retired(1);
    bus.instr_ready = 0;
    total++;
    if (bus.instret !== 32'd1) begin
      bad++;
      $display("FAIL restart_instret: instret=%0d, expected 1", bus.instret);
    end
    step();
    step();
  endtask
  task automatic test_fault();
    mem_on = 0;
    rst = 1;
    step();
    exp_addr.push_back(30'h100);
    rst = 0;
    step();
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (bus.fetch_fault !== 1'b0) begin
        bad++;
        $display("FAIL fault_early[%0d]: fetch_fault=%b, expected 0", i, bus.fetch_fault);
      end
    end
    step();
    total++;
    if (bus.fetch_fault !== 1'b1) begin
      bad++;
      $display("FAIL fault_set: fetch_fault=%b, expected 1", bus.fetch_fault);
    end
    inject = 1;
    repeat (3) step();
    total++;
    if (bus.fetch_fault !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL fault_sticky: fault=%b valid=%b req=%b, expected 1 0 0", bus.fetch_fault, bus.instr_valid, bus.imem_req);
    end
    rst = 1;
    #1;
    total++;
    if (bus.fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL fault_clear: fetch_fault=%b, expected 0", bus.fetch_fault);
    end
    mem_on = 1;
    exp_addr.push_back(30'h100); exp_addr.push_back(30'h101);
    exp_pc.push_back(30'h100);
    bus.instr_ready = 1;
    step();
    rst = 0;
    wait_retired(1);
    bus.instr_ready = 0;
    repeat (4) step();
    total++;
    if (bus.instret !== 32'd1 || exp_addr.size() != 0 || exp_pc.size() != 0) begin
      bad++;
      $display("FAIL fault_restart: instret=%0d addr_left=%0d pc_left=%0d, expected 1 0 0", bus.instret, exp_addr.size(), exp_pc.size());
    end
  endtask
  initial begin
    bus.imem_rvalid = 0;
    bus.imem_rdata = '0;
    bus.instr_ready = 0;
    bus.jmp_enable = 0;
    bus.jmp_addr = '0;
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          pend = 0;
          retired = 0;
          bus.imem_rvalid = 0;
        end else begin
          if (bus.instr_valid && bus.instr_ready) begin
            retired++;
            total++;
            if (exp_pc.size() == 0) begin
              bad++;
              $display("FAIL retire_pc: retire at instr_pc=%h, expected no retire", bus.instr_pc);
            end else begin
              e = exp_pc.pop_front();
              if (bus.instr_pc !== e || bus.instr !== word(e)) begin
                bad++;
                $display("FAIL retire_pc: instr_pc=%h instr=%h, expected %h %h", bus.instr_pc, bus.instr, e, word(e));
              end
            end
          end
          bus.imem_rvalid = 0;
          if (inject) begin
            bus.imem_rvalid = 1;
            bus.imem_rdata = 32'hDEAD_BEEF;
            inject = 0;
          end
          if (pend) begin
            if (pend_cnt == 0) begin
              bus.imem_rvalid = 1;
              bus.imem_rdata = word(pend_addr);
              pend = 0;
            end else pend_cnt--;
          end
          if (bus.imem_req) begin
            total++;
            if (exp_addr.size() == 0) begin
              bad++;
              $display("FAIL imem_addr: request at %h, expected no request", bus.imem_addr);
            end else begin
              e = exp_addr.pop_front();
              if (bus.imem_addr !== e) begin
                bad++;
                $display("FAIL imem_addr: request at %h, expected %h", bus.imem_addr, e);
              end
            end
            if (mem_on) begin
              pend = 1;
              pend_cnt = mem_delay;
              pend_addr = bus.imem_addr;
            end
          end
        end
      end
    join_none
    test_reset();
    test_sequential();
    test_jump();
    test_jmp_ignored();
    test_hold_stable();
    test_wrap();
    test_reset_midwait();
    test_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
